cache_controller: RTL and testbench

Processor-side snooping cache controller: the initiator end of the 9-bit shared coherence bus whose memory responder services readMiss and writeBack. It holds a small direct-mapped, MSI-coherent data cache for one processor, issues readMiss / writeBack / writeMiss commands on a granted bus slot, captures memory's reply from `memOut`, and snoops other caches' commands to downgrade or invalidate its own lines. One instance sits between each processor and the bus arbiter.

---
 rtl/cache_controller.sv | 150 +++++++++++++++
 tb/tb_cache_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Processor-side MSI snooping cache controller: a small direct-mapped cache that
// issues readMiss/writeBack/writeMiss on a granted bus slot and answers snoops.
module cache_controller #(
  parameter int LINES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpuReq,
  input  logic       cpuWrite,
  input  logic [2:0] cpuAddr,
  input  logic [3:0] cpuWdata,
  output logic       cpuReady,
  output logic [3:0] cpuRdata,
  output logic       busReq,
  input  logic       busGrant,
  output logic       busValid,
  output logic [8:0] busOut,
  input  logic [8:0] memOut,
  input  logic       snoopValid,
  input  logic [8:0] snoopIn,
  output logic [3:0] dbgState
);
  localparam int IW = $clog2(LINES);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    VWB_REQ   = 4'd1,
    VWB_ISSUE = 4'd2,
    RM_REQ    = 4'd3,
    RM_ISSUE  = 4'd4,
    WM_REQ    = 4'd5,
    WM_ISSUE  = 4'd6,
    SWB_REQ   = 4'd7,
    SWB_ISSUE = 4'd8,
    DONE      = 4'd9
  } state_t;

  typedef enum logic [1:0] {MSI_I = 2'd0, MSI_S = 2'd1, MSI_M = 2'd2} msi_t;

  state_t            r_state, w_next;
  logic [2:0]        r_tag  [LINES];
  logic [3:0]        r_data [LINES];
  msi_t              r_msi  [LINES];
  logic              r_swb_pend, r_swb_inv;
  logic [IW-1:0]     r_swb_idx;
  logic [8:0]        r_bus_out;
  logic              r_bus_valid;

  logic [IW-1:0]     w_idx, w_sidx;
  logic              w_hit, w_issue, w_snoop_act, w_snoop_wb, w_snoop_inv, w_swb;
  logic              w_unused;

  assign w_idx   = cpuAddr[IW-1:0];
  assign w_sidx  = snoopIn[4 +: IW];
  assign w_hit   = (r_msi[w_idx] != MSI_I) && (r_tag[w_idx] == cpuAddr);
  assign w_issue = (r_state == VWB_ISSUE) || (r_state == RM_ISSUE) ||
                   (r_state == WM_ISSUE)  || (r_state == SWB_ISSUE);

  // Snoops are ignored while we own the bus (our own ISSUE cycle).
  assign w_snoop_act = snoopValid && !w_issue && (r_msi[w_sidx] != MSI_I) &&
                       (r_tag[w_sidx] == snoopIn[6:4]);
  assign w_snoop_wb  = w_snoop_act && (r_msi[w_sidx] == MSI_M) &&
                       ((snoopIn[8:7] == 2'd0) || (snoopIn[8:7] == 2'd2));
  assign w_snoop_inv = w_snoop_act && (r_msi[w_sidx] == MSI_S) && (snoopIn[8:7] == 2'd2);
  assign w_swb       = r_swb_pend || w_snoop_wb;
  assign w_unused    = ^{memOut[8:4], snoopIn[3:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_swb)                                       w_next = SWB_REQ;
        else if (cpuReq && w_hit)                        w_next = (!cpuWrite || r_msi[w_idx] == MSI_M) ? DONE : WM_REQ;
        else if (cpuReq && r_msi[w_idx] == MSI_M)        w_next = VWB_REQ;
        else if (cpuReq)                                 w_next = cpuWrite ? WM_REQ : RM_REQ;
      end
      VWB_REQ:   if (w_swb) w_next = SWB_REQ; else if (busGrant) w_next = VWB_ISSUE;
      RM_REQ:    if (w_swb) w_next = SWB_REQ; else if (busGrant) w_next = RM_ISSUE;
      WM_REQ:    if (w_swb) w_next = SWB_REQ; else if (busGrant) w_next = WM_ISSUE;
      SWB_REQ:   if (busGrant) w_next = SWB_ISSUE;
      VWB_ISSUE: w_next = cpuWrite ? WM_REQ : RM_REQ;
      RM_ISSUE:  w_next = DONE;
      WM_ISSUE:  w_next = DONE;
      SWB_ISSUE: w_next = IDLE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_swb_pend  <= 1'b0;
      r_swb_inv   <= 1'b0;
      r_swb_idx   <= '0;
      r_bus_out   <= 9'h180;
      r_bus_valid <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]  <= 3'd0;
        r_data[i] <= 4'd0;
        r_msi[i]  <= MSI_I;
      end
    end else begin
      r_state <= w_next;
      if (w_snoop_inv) r_msi[w_sidx] <= MSI_I;
      if (w_snoop_wb) begin
        r_swb_pend <= 1'b1;
        r_swb_inv  <= (snoopIn[8:7] == 2'd2);
        r_swb_idx  <= w_sidx;
      end
      case (r_state)
        IDLE:      if (w_next == DONE && cpuWrite) r_data[w_idx] <= cpuWdata;
        VWB_ISSUE: r_msi[w_idx] <= MSI_I;
        RM_ISSUE: begin
          r_tag[w_idx]  <= cpuAddr;
          r_data[w_idx] <= memOut[3:0];
          r_msi[w_idx]  <= MSI_S;
        end
        WM_ISSUE: begin
          r_tag[w_idx]  <= cpuAddr;
          r_data[w_idx] <= cpuWdata;
          r_msi[w_idx]  <= MSI_M;
        end
        SWB_ISSUE: begin
          r_msi[r_swb_idx] <= r_swb_inv ? MSI_I : MSI_S;
          r_swb_pend       <= 1'b0;
        end
        default: ;
      endcase
      // Bus command is registered on entry to an ISSUE state so it is stable for that whole cycle.
      r_bus_valid <= 1'b0;
      r_bus_out   <= 9'h180;
      case (w_next)
        VWB_ISSUE: begin r_bus_valid <= 1'b1; r_bus_out <= {2'd1, r_tag[w_idx], r_data[w_idx]}; end
        RM_ISSUE:  begin r_bus_valid <= 1'b1; r_bus_out <= {2'd0, cpuAddr, 4'd0}; end
        WM_ISSUE:  begin r_bus_valid <= 1'b1; r_bus_out <= {2'd2, cpuAddr, cpuWdata}; end
        SWB_ISSUE: begin r_bus_valid <= 1'b1; r_bus_out <= {2'd1, r_tag[r_swb_idx], r_data[r_swb_idx]}; end
        default: ;
      endcase
    end
  end

  assign busReq   = (r_state == VWB_REQ) || (r_state == RM_REQ) || (r_state == WM_REQ) ||
                    (r_state == SWB_REQ) || w_issue;
  assign busValid = r_bus_valid;
  assign busOut   = r_bus_out;
  assign cpuReady = (r_state == DONE);
  assign cpuRdata = (r_state == DONE) ? r_data[w_idx] : 4'd0;
  assign dbgState = r_state;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a small memory responder, a bus log,
// and hand-computed expectations checked with immediate assertions.
module tb_cache_controller;
  logic       clock = 1'b0;
  logic       reset, cpuReq, cpuWrite, cpuReady, busReq, busGrant, busValid, snoopValid;
  logic [2:0] cpuAddr;
  logic [3:0] cpuWdata, cpuRdata, dbgState;
  logic [8:0] busOut, memOut, snoopIn;

  int         n_checks = 0;
  int         n_err    = 0;
  int         base;
  int         n;
  logic [3:0] mem [8];
  logic [8:0] bus_log [$];

  localparam logic [3:0] S_IDLE = 4'd0, S_RM_REQ = 4'd3, S_SWB_REQ = 4'd7;

  cache_controller #(.LINES(4)) dut (
    .clock(clock), .reset(reset), .cpuReq(cpuReq), .cpuWrite(cpuWrite),
    .cpuAddr(cpuAddr), .cpuWdata(cpuWdata), .cpuReady(cpuReady), .cpuRdata(cpuRdata),
    .busReq(busReq), .busGrant(busGrant), .busValid(busValid), .busOut(busOut),
    .memOut(memOut), .snoopValid(snoopValid), .snoopIn(snoopIn), .dbgState(dbgState)
  );

  always #5 clock = ~clock;

  // Memory responder: answers the command on the bus within the cycle, absorbs writebacks.
  assign memOut = {5'd0, mem[busOut[6:4]]};
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
      mem[5] <= 4'hA;
      mem[1] <= 4'h7;
      mem[2] <= 4'hC;
    end else if (busValid) begin
      bus_log.push_back(busOut);
      if (busOut[8:7] == 2'd1) mem[busOut[6:4]] <= busOut[3:0];
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [2:0] a, input logic [3:0] d);
    cpuReq = 1'b1; cpuWrite = w; cpuAddr = a; cpuWdata = d;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (cpuReady) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic release_req();
    cpuReq = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1; cpuReq = 1'b0; cpuWrite = 1'b0; cpuAddr = 3'd0; cpuWdata = 4'd0;
    busGrant = 1'b1; snoopValid = 1'b0; snoopIn = 9'h180;
    repeat (2) cyc();
    chk("rst_busOut", busOut, 9'h180);
    chk("rst_busValid", busValid, 0);
    chk("rst_busReq", busReq, 0);
    chk("rst_cpuReady", cpuReady, 0);
    chk("rst_cpuRdata", cpuRdata, 0);
    chk("rst_state", dbgState, S_IDLE);
    for (int i = 0; i < 4; i++) begin
      chk("rst_msi", dut.r_msi[i], 0);
      chk("rst_tag", dut.r_tag[i], 0);
      chk("rst_data", dut.r_data[i], 0);
    end
    reset = 1'b0;

    // Read miss, immediate grant.
    req(1'b0, 3'd5, 4'd0);
    cyc();
    chk("rm_c1_state", dbgState, S_RM_REQ);
    chk("rm_c1_busReq", busReq, 1);
    cyc();
    chk("rm_c2_busOut", busOut, 9'h050);
    chk("rm_c2_busValid", busValid, 1);
    cyc();
    chk("rm_c3_ready", cpuReady, 1);
    chk("rm_c3_rdata", cpuRdata, 4'hA);
    cpuReq = 1'b0;
    cyc();
    chk("rm_after_ready", cpuReady, 0);
    chk("rm_after_busReq", busReq, 0);
    chk("rm_after_busOut", busOut, 9'h180);

    // Read hit.
    base = bus_log.size();
    req(1'b0, 3'd5, 4'd0);
    wait_ready(n);
    chk("hit_latency", n, 1);
    chk("hit_rdata", cpuRdata, 4'hA);
    chk("hit_no_bus", bus_log.size() - base, 0);
    release_req();

    // Write hit on S: writeMiss upgrade.
    base = bus_log.size();
    req(1'b1, 3'd5, 4'h3);
    wait_ready(n);
    chk("wm_latency", n, 3);
    chk("wm_rdata", cpuRdata, 4'h3);
    chk("wm_bus_count", bus_log.size() - base, 1);
    chk("wm_busOut", bus_log[base], 9'h153);
    chk("wm_msi", dut.r_msi[1], 2);
    chk("wm_data", dut.r_data[1], 4'h3);
    release_req();

    // Read miss with an M victim.
    base = bus_log.size();
    req(1'b0, 3'd1, 4'd0);
    wait_ready(n);
    chk("vwb_latency", n, 5);
    chk("vwb_rdata", cpuRdata, 4'h7);
    chk("vwb_bus_count", bus_log.size() - base, 2);
    chk("vwb_first", bus_log[base], 9'h0D3);
    chk("vwb_second", bus_log[base+1], 9'h010);
    chk("vwb_mem5", mem[5], 4'h3);
    chk("vwb_msi", dut.r_msi[1], 1);
    chk("vwb_tag", dut.r_tag[1], 3'd1);
    release_req();

    // Restore line 1 to M (tag 5, data 3): write miss with an S victim.
    base = bus_log.size();
    req(1'b1, 3'd5, 4'h3);
    wait_ready(n);
    chk("rest_latency", n, 3);
    chk("rest_busOut", bus_log[base], 9'h153);
    chk("rest_msi", dut.r_msi[1], 2);
    release_req();

    // Snoop readMiss on our M line.
    busGrant = 1'b0;
    snoopValid = 1'b1; snoopIn = 9'h050;
    cyc();
    snoopValid = 1'b0; snoopIn = 9'h180;
    chk("snp_busReq", busReq, 1);
    chk("snp_state", dbgState, S_SWB_REQ);
    busGrant = 1'b1;
    cyc();
    chk("snp_busOut", busOut, 9'h0D3);
    chk("snp_busValid", busValid, 1);
    cyc();
    chk("snp_busReq_drop", busReq, 0);
    chk("snp_msi", dut.r_msi[1], 1);

    // Snoop writeMiss on our S line.
    base = bus_log.size();
    snoopValid = 1'b1; snoopIn = 9'h150;
    cyc();
    snoopValid = 1'b0; snoopIn = 9'h180;
    chk("inv_msi", dut.r_msi[1], 0);
    chk("inv_busReq", busReq, 0);
    cyc();
    chk("inv_no_bus", bus_log.size() - base, 0);

    // Read miss with three cycles of grant delay.
    busGrant = 1'b0;
    base = bus_log.size();
    n = 0;
    req(1'b0, 3'd2, 4'd0);
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c <= 4) chk("dly_busReq", busReq, 1);
      if (c == 4) busGrant = 1'b1;
      if (cpuReady) begin
        n = c;
        break;
      end
    end
    chk("dly_latency", n, 6);
    chk("dly_rdata", cpuRdata, 4'hC);
    chk("dly_busOut", bus_log[base], 9'h020);
    release_req();

    // Reset during RM_REQ.
    busGrant = 1'b0;
    req(1'b0, 3'd3, 4'd0);
    cyc();
    chk("rr_state_before", dbgState, S_RM_REQ);
    reset = 1'b1;
    cyc();
    chk("rr_state", dbgState, S_IDLE);
    chk("rr_busReq", busReq, 0);
    chk("rr_busOut", busOut, 9'h180);
    for (int i = 0; i < 4; i++) chk("rr_msi", dut.r_msi[i], 0);
    cpuReq = 1'b0;
    reset = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
